// File: rtl/drf_io_pkg.sv
// +----------------------------------------------------------------------------+
// | drf_io_pkg : shared constants for the DRF memory-mapped I/O port block     |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package drf_io_pkg;

  localparam int BUS_W = 8;

  typedef logic [1:0] reg_sel_t;

  localparam reg_sel_t REG_IN   = 2'd0;
  localparam reg_sel_t REG_OUT  = 2'd1;
  localparam reg_sel_t REG_TOG  = 2'd2;
  localparam reg_sel_t REG_STAT = 2'd3;

  localparam int STAT_CHG = 0;
  localparam int STAT_IE  = 1;

  function automatic logic [BUS_W-1:0] stat_byte(input logic chg, input logic ie);
    logic [BUS_W-1:0] v;
    v           = '0;
    v[STAT_CHG] = chg;
    v[STAT_IE]  = ie;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/drf_io_channel.sv
// +----------------------------------------------------------------------------+
// | drf_io_channel : one port - input synchroniser, OUT latch, CHG/IE status   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module drf_io_channel
  import drf_io_pkg::*;
#(
  parameter int PORT_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  warm_done_i,
  input  logic                  wr_en_i,
  input  reg_sel_t              reg_sel_i,
  input  logic [PORT_WIDTH-1:0] wdata_i,
  input  logic                  stat_clr_i,
  input  logic                  stat_ie_i,
  input  logic [PORT_WIDTH-1:0] pin_i,
  output logic [PORT_WIDTH-1:0] in_o,
  output logic [PORT_WIDTH-1:0] out_o,
  output logic                  chg_o,
  output logic                  ie_o
);

  logic [PORT_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [PORT_WIDTH-1:0] prev_q;
  logic [PORT_WIDTH-1:0] out_q, out_d;
  logic                  chg_q, chg_d;
  logic                  ie_q, ie_d;
  logic                  chg_set;
  logic                  chg_clr;

  assign in_o  = sync_q[SYNC_STAGES-1];
  assign out_o = out_q;
  assign chg_o = chg_q;
  assign ie_o  = ie_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A new change in the same cycle as a software clear keeps CHG set.
  assign chg_set = warm_done_i && (sync_q[SYNC_STAGES-1] != prev_q);
  assign chg_clr = wr_en_i && (reg_sel_i == REG_STAT) && stat_clr_i;

  always_comb begin
    out_d = out_q;
    ie_d  = ie_q;
    chg_d = chg_set | (chg_q & ~chg_clr);
    if (wr_en_i) begin
      case (reg_sel_i)
        REG_OUT:  out_d = wdata_i;
        REG_TOG:  out_d = out_q ^ wdata_i;
        REG_STAT: ie_d  = stat_ie_i;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      chg_q <= 1'b0;
      ie_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      chg_q <= chg_d;
      ie_q  <= ie_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/drf_io_ports.sv
// +----------------------------------------------------------------------------+
// | drf_io_ports : NUM_PORTS memory-mapped I/O ports on the 8-bit DRF bus      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module drf_io_ports
  import drf_io_pkg::*;
#(
  parameter int         NUM_PORTS   = 4,
  parameter int         PORT_WIDTH  = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BASE_ADDR   = 8'hF0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_addr,
  input  logic [7:0]                      in_data,
  input  logic                            in_write_en,
  input  logic                            in_read_en,
  output logic [7:0]                      out_data,
  output logic                            out_data_valid,
  output logic                            out_hit,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] in_port,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] out_port,
  output logic                            out_irq
);

  localparam int         WIN_END   = int'(BASE_ADDR) + 4 * NUM_PORTS;
  localparam logic [8:0] WIN_END_9 = 9'(WIN_END);
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);

  logic [7:0]            offset;
  logic [5:0]            port_idx;
  reg_sel_t              reg_sel;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  warm_done;
  logic [2:0]            warm_q, warm_d;
  logic [7:0]            rd_val;
  logic [7:0]            data_q;
  logic                  valid_q;
  logic                  irq_q;
  logic [NUM_PORTS-1:0]  chg_vec;
  logic [NUM_PORTS-1:0]  ie_vec;
  logic [PORT_WIDTH-1:0] in_val  [NUM_PORTS];
  logic [PORT_WIDTH-1:0] out_val [NUM_PORTS];

  assign offset   = in_addr - BASE_ADDR;
  assign port_idx = offset[7:2];
  assign reg_sel  = offset[1:0];
  assign out_hit  = ({1'b0, in_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, in_addr} < WIN_END_9);

  // A simultaneous write wins; the read is dropped.
  assign wr_acc = out_hit && in_write_en;
  assign rd_acc = out_hit && in_read_en && !in_write_en;

  // Masks the reset-value to first-sample transition on every port.
  assign warm_done = (warm_q == WARM_LAST);
  assign warm_d    = warm_done ? warm_q : warm_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) warm_q <= '0;
    else     warm_q <= warm_d;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    drf_io_channel #(
      .PORT_WIDTH  (PORT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .warm_done_i (warm_done),
      .wr_en_i     (wr_acc && (port_idx == 6'(p))),
      .reg_sel_i   (reg_sel),
      .wdata_i     (in_data[PORT_WIDTH-1:0]),
      .stat_clr_i  (in_data[STAT_CHG]),
      .stat_ie_i   (in_data[STAT_IE]),
      .pin_i       (in_port[p*PORT_WIDTH +: PORT_WIDTH]),
      .in_o        (in_val[p]),
      .out_o       (out_val[p]),
      .chg_o       (chg_vec[p]),
      .ie_o        (ie_vec[p])
    );
    assign out_port[p*PORT_WIDTH +: PORT_WIDTH] = out_val[p];
  end

  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_idx == 6'(p)) begin
        case (reg_sel)
          REG_IN:   rd_val[PORT_WIDTH-1:0] = in_val[p];
          REG_OUT:  rd_val[PORT_WIDTH-1:0] = out_val[p];
          REG_STAT: rd_val = stat_byte(chg_vec[p], ie_vec[p]);
          default:  rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) data_q <= rd_val;
      irq_q <= |(chg_vec & ie_vec);
    end
  end

  assign out_data       = data_q;
  assign out_data_valid = valid_q;
  assign out_irq        = irq_q;

endmodule

`default_nettype wire
